// File: rtl/student_fir_sample_seq.sv
// Sample delay-line sequencer: writes each new sample into the ring through port A,
// then streams the newest NumTaps samples (newest first) out of port B to the MAC lanes.
module student_fir_sample_seq #(
  parameter int AddrWidth = 10,
  parameter int DataSize  = 16,
  parameter int NumTaps   = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 sample_valid_i,
  input  logic [DataSize-1:0]  sample_i,
  output logic                 ena_o,
  output logic                 wea_o,
  output logic [AddrWidth-1:0] addra_o,
  output logic [DataSize-1:0]  dia_o,
  output logic                 enb_o,
  output logic [AddrWidth-1:0] addrb_o,
  input  logic [DataSize-1:0]  dob_i,
  output logic                 tap_valid_o,
  output logic [DataSize-1:0]  tap_data_o,
  output logic [AddrWidth-1:0] tap_idx_o,
  output logic                 tap_first_o,
  output logic                 tap_last_o,
  output logic                 busy_o,
  output logic                 overflow_o
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  localparam logic [AddrWidth-1:0] LastK = AddrWidth'(NumTaps - 1);
  localparam logic [AddrWidth-1:0] One   = AddrWidth'(1);

  state_e               state;
  logic [AddrWidth-1:0] wr_ptr;
  logic [AddrWidth-1:0] base_q;
  logic [AddrWidth-1:0] k;
  logic [DataSize-1:0]  data_q;
  logic [DataSize-1:0]  pend_q;
  logic                 pend_full;
  logic                 overflow_q;
  logic                 tap_valid_q;
  logic [AddrWidth-1:0] tap_idx_q;
  logic                 tap_first_q;
  logic                 tap_last_q;

  // NOTE: every register here uses <= so all state updates see the same pre-edge
  // values regardless of statement order; = in a clocked block creates order races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      base_q      <= '0;
      k           <= '0;
      data_q      <= '0;
      pend_q      <= '0;
      pend_full   <= 1'b0;
      overflow_q  <= 1'b0;
      tap_valid_q <= 1'b0;
      tap_idx_q   <= '0;
      tap_first_q <= 1'b0;
      tap_last_q  <= 1'b0;
    end else if (clear_i) begin
      // RAM contents, base_q and the data registers are deliberately left alone.
      state       <= IDLE;
      wr_ptr      <= '0;
      k           <= '0;
      pend_full   <= 1'b0;
      overflow_q  <= 1'b0;
      tap_valid_q <= 1'b0;
      tap_idx_q   <= '0;
      tap_first_q <= 1'b0;
      tap_last_q  <= 1'b0;
    end else begin
      // Tap markers are delayed one cycle to line up with the RAM read latency.
      tap_valid_q <= (state == READ);
      tap_idx_q   <= (state == READ) ? k : '0;
      tap_first_q <= (state == READ) && (k == '0);
      tap_last_q  <= (state == READ) && (k == LastK);

      if (sample_valid_i && (state == WRITE || state == READ)) begin
        if (!pend_full) begin
          pend_q    <= sample_i;
          pend_full <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (sample_valid_i) begin
            data_q <= sample_i;
            state  <= WRITE;
          end
        end
        WRITE: begin
          base_q <= wr_ptr;
          wr_ptr <= wr_ptr + One;
          k      <= '0;
          state  <= READ;
        end
        READ: begin
          k <= k + One;
          if (k == LastK) state <= DRAIN;
        end
        DRAIN: begin
          // The slot is consumed here, so a sample arriving now refills it.
          if (pend_full) begin
            data_q    <= pend_q;
            state     <= WRITE;
            pend_full <= sample_valid_i;
            if (sample_valid_i) pend_q <= sample_i;
          end else if (sample_valid_i) begin
            data_q <= sample_i;
            state  <= WRITE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ena_o       = (state == WRITE);
  assign wea_o       = (state == WRITE);
  assign addra_o     = (state == WRITE) ? wr_ptr : '0;
  assign dia_o       = (state == WRITE) ? data_q : '0;
  assign enb_o       = (state == READ);
  assign addrb_o     = (state == READ) ? (base_q - k) : '0;
  assign busy_o      = (state != IDLE);
  assign overflow_o  = overflow_q;
  assign tap_valid_o = tap_valid_q;
  assign tap_data_o  = tap_valid_q ? dob_i : '0;
  assign tap_idx_o   = tap_idx_q;
  assign tap_first_o = tap_first_q;
  assign tap_last_o  = tap_last_q;

endmodule

// File: tb/tb_student_fir_sample_seq.sv
// Scoreboard bench: directed stimulus pushes expected RAM writes, reads and taps;
// per-instance monitors pop and compare whenever the DUT drives them.
module tb_student_fir_sample_seq;

  localparam int AwA = 10;
  localparam int NtA = 4;
  localparam int AwB = 3;
  localparam int NtB = 8;
  localparam int Dw  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {int addr; int data;} wr_t;
  typedef struct {int data; int idx; int first; int last;} tap_t;

  wr_t  a_wr_q[$];
  wr_t  b_wr_q[$];
  int   a_rd_q[$];
  tap_t a_tap_q[$];
  tap_t b_tap_q[$];

  // Instance A: 1024-entry ring, 4 taps
  logic           a_clear = 1'b0, a_sv = 1'b0;
  logic [Dw-1:0]  a_sample = '0;
  logic           a_ena, a_wea, a_enb, a_tv, a_tf, a_tl, a_busy, a_ovf;
  logic [AwA-1:0] a_addra, a_addrb, a_ti;
  logic [Dw-1:0]  a_dia, a_td;
  logic [Dw-1:0]  a_dob = '0;
  logic [Dw-1:0]  a_mem [2**AwA] = '{default: '0};

  // Instance B: 8-entry ring, 8 taps (every tap sequence sweeps the whole ring)
  logic           b_clear = 1'b0, b_sv = 1'b0;
  logic [Dw-1:0]  b_sample = '0;
  logic           b_ena, b_wea, b_enb, b_tv, b_tf, b_tl, b_busy, b_ovf;
  logic [AwB-1:0] b_addra, b_addrb, b_ti;
  logic [Dw-1:0]  b_dia, b_td;
  logic [Dw-1:0]  b_dob = '0;
  logic [Dw-1:0]  b_mem [2**AwB] = '{default: '0};

  student_fir_sample_seq #(.AddrWidth(AwA), .DataSize(Dw), .NumTaps(NtA)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear),
    .sample_valid_i(a_sv), .sample_i(a_sample),
    .ena_o(a_ena), .wea_o(a_wea), .addra_o(a_addra), .dia_o(a_dia),
    .enb_o(a_enb), .addrb_o(a_addrb), .dob_i(a_dob),
    .tap_valid_o(a_tv), .tap_data_o(a_td), .tap_idx_o(a_ti),
    .tap_first_o(a_tf), .tap_last_o(a_tl), .busy_o(a_busy), .overflow_o(a_ovf)
  );

  student_fir_sample_seq #(.AddrWidth(AwB), .DataSize(Dw), .NumTaps(NtB)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear),
    .sample_valid_i(b_sv), .sample_i(b_sample),
    .ena_o(b_ena), .wea_o(b_wea), .addra_o(b_addra), .dia_o(b_dia),
    .enb_o(b_enb), .addrb_o(b_addrb), .dob_i(b_dob),
    .tap_valid_o(b_tv), .tap_data_o(b_td), .tap_idx_o(b_ti),
    .tap_first_o(b_tf), .tap_last_o(b_tl), .busy_o(b_busy), .overflow_o(b_ovf)
  );

  // Behavioural dual-port RAMs with one-cycle read latency
  always @(posedge clk) begin
    if (a_ena && a_wea) a_mem[a_addra] <= a_dia;
    if (a_enb) a_dob <= a_mem[a_addrb];
    if (b_ena && b_wea) b_mem[b_addra] <= b_dia;
    if (b_enb) b_dob <= b_mem[b_addrb];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic tap_t mk_tap(input int d, input int k, input int nt);
    tap_t t;
    t.data  = d;
    t.idx   = k;
    t.first = (k == 0) ? 1 : 0;
    t.last  = (k == nt - 1) ? 1 : 0;
    return t;
  endfunction

  // Monitor A
  wr_t  a_w;
  tap_t a_t;
  int   a_ra;
  always @(negedge clk) begin
    if (a_ena) begin
      check("a_wr_expected", 32'(a_wr_q.size() > 0), 32'd1);
      if (a_wr_q.size() > 0) begin
        a_w = a_wr_q.pop_front();
        check("a_wr_addr", 32'(a_addra), a_w.addr);
        check("a_wr_data", 32'(a_dia), a_w.data);
        check("a_wea", 32'(a_wea), 32'd1);
      end
    end
    if (a_enb) begin
      check("a_ports_exclusive", 32'(a_ena), 32'd0);
      check("a_rd_expected", 32'(a_rd_q.size() > 0), 32'd1);
      if (a_rd_q.size() > 0) begin
        a_ra = a_rd_q.pop_front();
        check("a_rd_addr", 32'(a_addrb), a_ra);
      end
    end
    if (a_tv) begin
      check("a_tap_expected", 32'(a_tap_q.size() > 0), 32'd1);
      if (a_tap_q.size() > 0) begin
        a_t = a_tap_q.pop_front();
        check("a_tap_data", 32'(a_td), a_t.data);
        check("a_tap_idx", 32'(a_ti), a_t.idx);
        check("a_tap_first", 32'(a_tf), a_t.first);
        check("a_tap_last", 32'(a_tl), a_t.last);
      end
    end else begin
      check("a_tap_idle_zero", 32'({a_td, a_ti, a_tf, a_tl}), 32'd0);
    end
  end

  // Monitor B
  wr_t  b_w;
  tap_t b_t;
  always @(negedge clk) begin
    if (b_ena) begin
      check("b_wr_expected", 32'(b_wr_q.size() > 0), 32'd1);
      if (b_wr_q.size() > 0) begin
        b_w = b_wr_q.pop_front();
        check("b_wr_addr", 32'(b_addra), b_w.addr);
        check("b_wr_data", 32'(b_dia), b_w.data);
      end
    end
    if (b_enb) check("b_ports_exclusive", 32'(b_ena), 32'd0);
    if (b_tv) begin
      check("b_tap_expected", 32'(b_tap_q.size() > 0), 32'd1);
      if (b_tap_q.size() > 0) begin
        b_t = b_tap_q.pop_front();
        check("b_tap_data", 32'(b_td), b_t.data);
        check("b_tap_idx", 32'(b_ti), b_t.idx);
        check("b_tap_first", 32'(b_tf), b_t.first);
        check("b_tap_last", 32'(b_tl), b_t.last);
      end
    end
  end

  // Callers sit just after a rising edge; the strobe is captured at the next edge.
  task automatic send_a(input logic [Dw-1:0] d);
    a_sv = 1'b1;
    a_sample = d;
    @(posedge clk); #1;
    a_sv = 1'b0;
  endtask

  task automatic send_b(input logic [Dw-1:0] d);
    b_sv = 1'b1;
    b_sample = d;
    @(posedge clk); #1;
    b_sv = 1'b0;
  endtask

  // Counts consecutive busy cycles, bounded so a stuck FSM still reaches the summary.
  task automatic wait_idle_a(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!a_busy || n >= 200) break;
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic push_a(input int waddr, input int wdata, input int rd[NtA], input int td[NtA]);
    a_wr_q.push_back('{waddr, wdata});
    for (int i = 0; i < NtA; i++) begin
      a_rd_q.push_back(rd[i]);
      a_tap_q.push_back(mk_tap(td[i], i, NtA));
    end
  endtask

  int n;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("a_reset_ctrl", 32'({a_ena, a_wea, a_enb, a_tv, a_tf, a_tl, a_busy, a_ovf}), 32'd0);
    check("a_reset_addr", 32'({a_addra, a_addrb, a_ti}), 32'd0);
    check("a_reset_data", 32'({a_dia, a_td}), 32'd0);
    check("b_reset_ctrl", 32'({b_ena, b_enb, b_tv, b_busy, b_ovf}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single sample after reset: read addresses wrap below zero
    push_a(0, 'h1111, '{0, 1023, 1022, 1021}, '{'h1111, 0, 0, 0});
    send_a('h1111);
    wait_idle_a(n);
    check("a_single_busy_cycles", n, 32'd6);

    // Sample B lands in A's READ phase and runs back-to-back
    push_a(1, 'h2222, '{1, 0, 1023, 1022}, '{'h2222, 'h1111, 0, 0});
    push_a(2, 'h3333, '{2, 1, 0, 1023}, '{'h3333, 'h2222, 'h1111, 0});
    send_a('h2222);
    @(posedge clk); #1;
    send_a('h3333);
    wait_idle_a(n);
    check("a_pending_busy_cycles", n, 32'd10);
    check("a_pending_no_overflow", 32'(a_ovf), 32'd0);

    // B and C both arrive during A: C is dropped, overflow is sticky until clear
    push_a(3, 'h4444, '{3, 2, 1, 0}, '{'h4444, 'h3333, 'h2222, 'h1111});
    push_a(4, 'h5555, '{4, 3, 2, 1}, '{'h5555, 'h4444, 'h3333, 'h2222});
    send_a('h4444);
    @(posedge clk); #1;
    send_a('h5555);
    send_a('h6666);
    wait_idle_a(n);
    check("a_overflow_busy_cycles", n, 32'd9);
    check("a_overflow_set", 32'(a_ovf), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("a_overflow_sticky", 32'(a_ovf), 32'd1);
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
    check("a_overflow_cleared", 32'(a_ovf), 32'd0);

    // Clear in the second READ cycle; a sample presented with it is ignored
    a_wr_q.push_back('{0, 'h7777});
    a_rd_q.push_back(0);
    a_rd_q.push_back(1023);
    a_tap_q.push_back(mk_tap('h7777, 0, NtA));
    send_a('h7777);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_clear = 1'b1;
    a_sv = 1'b1;
    a_sample = 'hdead;
    @(posedge clk); #1;
    a_clear = 1'b0;
    a_sv = 1'b0;
    check("a_clear_idle", 32'(a_busy), 32'd0);
    check("a_clear_tap_flushed", 32'(a_tv), 32'd0);
    check("a_clear_enb", 32'(a_enb), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    push_a(0, 'h8888, '{0, 1023, 1022, 1021}, '{'h8888, 0, 0, 0});
    send_a('h8888);
    wait_idle_a(n);
    check("a_after_clear_busy_cycles", n, 32'd6);

    // Ring wrap on the 8-entry instance: 10 samples, 12 cycles apart
    for (int s = 1; s <= 10; s++) begin
      b_wr_q.push_back('{(s - 1) % 8, s});
      for (int k = 0; k < NtB; k++) b_tap_q.push_back(mk_tap((s - k >= 1) ? s - k : 0, k, NtB));
      send_b(Dw'(s));
      repeat (11) @(posedge clk);
      #1;
    end
    check("b_wrap_no_overflow", 32'(b_ovf), 32'd0);

    // Reset mid-READ with a pending sample: outputs drop at once, nothing resumes
    a_wr_q.push_back('{1, 'h9999});
    a_rd_q.push_back(1);
    a_rd_q.push_back(0);
    a_tap_q.push_back(mk_tap('h9999, 0, NtA));
    send_a('h9999);
    @(posedge clk); #1;
    send_a('haaaa);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("a_async_reset_ctrl", 32'({a_ena, a_wea, a_enb, a_tv, a_tf, a_tl, a_busy, a_ovf}), 32'd0);
    check("a_async_reset_addr", 32'({a_addra, a_addrb, a_ti}), 32'd0);
    check("a_async_reset_data", 32'({a_dia, a_td}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("a_reset_stays_idle", 32'(a_busy), 32'd0);
    push_a(0, 'hbbbb, '{0, 1023, 1022, 1021}, '{'hbbbb, 0, 0, 0});
    send_a('hbbbb);
    wait_idle_a(n);
    check("a_after_reset_busy_cycles", n, 32'd6);

    repeat (5) @(posedge clk);
    #1;
    check("a_wr_q_drained", a_wr_q.size(), 32'd0);
    check("a_rd_q_drained", a_rd_q.size(), 32'd0);
    check("a_tap_q_drained", a_tap_q.size(), 32'd0);
    check("b_wr_q_drained", b_wr_q.size(), 32'd0);
    check("b_tap_q_drained", b_tap_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/student_fir_sample_seq.md
# student_fir_sample_seq

Sequencer for the FIR sample delay line. It accepts one input sample at a time and writes it into the dual-port sample RAM through port A at a circular write pointer. It then reads the newest `NumTaps` samples, newest to oldest, through port B and streams them to the MAC datapath with tap index and first/last markers. It sits between the audio sample source and the sample DPRAM/MAC lanes, and is the only driver of the RAM's datapath ports.

## Interface
- `AddrWidth`, default 10: RAM address width; the ring holds 2**AddrWidth samples.
- `DataSize`, default 16: sample width.
- `NumTaps`, default 1024: taps per sequence; legal range is 1..2**AddrWidth.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `clear_i`, in, 1: synchronous clear of pointer, pending slot and flags.
- `sample_valid_i`, in, 1: single-cycle strobe marking a new sample.
- `sample_i`, in, DataSize: sample data.
- `ena_o`, out, 1: RAM port A enable.
- `wea_o`, out, 1: RAM port A write enable.
- `addra_o`, out, AddrWidth: RAM port A address.
- `dia_o`, out, DataSize: RAM port A write data.
- `enb_o`, out, 1: RAM port B enable.
- `addrb_o`, out, AddrWidth: RAM port B address.
- `dob_i`, in, DataSize: RAM port B read data, valid the cycle after `enb_o`.
- `tap_valid_o`, out, 1: `tap_data_o` is valid.
- `tap_data_o`, out, DataSize: equals `dob_i`.
- `tap_idx_o`, out, AddrWidth: tap number k (0 = newest sample).
- `tap_first_o`, out, 1: asserted with k = 0.
- `tap_last_o`, out, 1: asserted with k = NumTaps-1.
- `busy_o`, out, 1: high when the FSM is not in IDLE.
- `overflow_o`, out, 1: sticky flag, a sample was dropped.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
  - IDLE: `sample_valid_i` loads `sample_i` into `data_q` and moves to WRITE.
  - WRITE (1 cycle): drive `ena_o = wea_o = 1`, `addra_o = wr_ptr`, `dia_o = data_q`. Set `base_q <= wr_ptr` and `wr_ptr <= wr_ptr + 1` (mod 2**AddrWidth). Go to READ with k = 0.
  - READ (NumTaps cycles): drive `enb_o = 1`, `addrb_o = (base_q - k) mod 2**AddrWidth`, then k++. Leave for DRAIN after k = NumTaps-1.
  - DRAIN (1 cycle): the last tap returns. Go to WRITE if the pending slot is full (it loads `data_q` and empties), otherwise go to IDLE.
- Tap output: `tap_valid_o`, `tap_idx_o`, `tap_first_o` and `tap_last_o` are registered copies of the READ-cycle `enb_o`, k and first/last flags, so they align with `dob_i`.
- Pending slot (one deep):
  - `sample_valid_i` outside IDLE stores the sample in the slot if it is empty.
  - If the slot is full, the sample is dropped and `overflow_o` is set. The slot keeps its older sample.
  - In DRAIN, the slot is consumed and a new `sample_valid_i` in the same cycle refills it. This is not an overflow.
- Outputs when not active: RAM outputs are 0 outside WRITE/READ. Tap outputs are 0 when `tap_valid_o` is 0.
- Ring wrap: address subtraction wraps modulo 2**AddrWidth. With wr_ptr = 0, taps read addresses 0, 2**AddrWidth-1, and so on. Samples older than 2**AddrWidth are overwritten.
- `clear_i` has priority over all other activity:
  - next state IDLE, `wr_ptr = 0`, pending slot empty, `overflow_o = 0`, tap pipeline flushed;
  - a sample presented in the same cycle is ignored;
  - RAM contents are not cleared.
- Reset: `rst_ni` low at any time, including mid-sequence, forces the same state as `clear_i`, asynchronously. The aborted sequence emits no further taps.

## Timing
- Reset values: every output is 0. Internally, FSM = IDLE, `wr_ptr = 0`, `base_q = 0`, k = 0.
- Latency for a sample strobed in IDLE at edge t:
  - WRITE cycle is t+1;
  - READ cycles are t+2 .. t+1+NumTaps;
  - `tap_valid_o` is high for cycles t+3 .. t+2+NumTaps (DRAIN = t+2+NumTaps);
  - IDLE (or WRITE, if a sample is pending) from t+3+NumTaps.
- Sample period: full throughput without drops needs spacing of at least NumTaps+2 cycles.
- Port collisions: the write at address A (WRITE) always precedes the read of A (first READ). Ports A and B are never driven on the same cycle.
- `busy_o` is high from WRITE through DRAIN inclusive.

## Test plan
- Single sample, NumTaps = 4, after reset: sample 0x1111 at t -> write to addr 0 at t+1; `addrb_o` = 0, 1023, 1022, 1021; `tap_idx_o` 0..3 at t+3..t+6 with first/last flags on taps 0 and 3; `busy_o` low at t+7.
- Wrap, AddrWidth = 3, NumTaps = 8: feed 10 samples 1..10 spaced 12 cycles apart -> 10th sequence returns 10, 9, ..., 3 and `addra_o` wraps 7 -> 0.
- Pending slot: sample B arrives in a READ cycle of sample A -> after A's DRAIN, WRITE of B follows immediately with no IDLE cycle; `overflow_o` stays 0.
- Overflow: samples B and C both arrive during A's sequence -> B is processed, C is dropped, `overflow_o` = 1 until `clear_i`.
- `clear_i` mid-READ -> next cycle IDLE, `tap_valid_o` 0 the following cycle, next sample written to addr 0.
- `rst_ni` pulsed mid-sequence with a pending sample -> all outputs 0 immediately, pending sample discarded, no taps after reset release.
